// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - binary to multiplexed seven-segment display controller
//
// Converts an unsigned binary value to BCD with a sequential double-dabble
// engine (one add-3/shift step per clock), latches the result into a display
// register and time-multiplexes it onto a common-anode seven-segment bank.
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   binary_in    unsigned value to display, captured on load
//   load         start a conversion (ignored while busy)
//   dp_mask      active-high decimal point per digit, bit 0 = units
//   enable       low blanks the display; scan counters keep running
//   busy         conversion in progress
//   done         one-cycle pulse when the display register is updated
//   overflow     displayed value needs more than N_DIGITS digits
//   segments_out {a,b,c,d,e,f,g,dp}, active low, registered
//   anodes_out   active-low digit select, registered
module seven_seg_scan_ctrl #(
  parameter int N_DIGITS    = 8,
  parameter int BIN_WIDTH   = 24,
  parameter int REFRESH_DIV = 65536,
  parameter int BLANK_LZ    = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [BIN_WIDTH-1:0] binary_in,
  input  logic                 load,
  input  logic [N_DIGITS-1:0]  dp_mask,
  input  logic                 enable,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [7:0]           segments_out,
  output logic [N_DIGITS-1:0]  anodes_out
);

  // floor(BIN_WIDTH*log10(2))+1 is never smaller than the decimal digit count
  // of 2**BIN_WIDTH-1, so the accumulator can hold every convertible value.
  localparam int BCD_DIGITS = (BIN_WIDTH * 30103) / 100000 + 1;
  localparam int ACC_DIGITS = (BCD_DIGITS > N_DIGITS) ? BCD_DIGITS : N_DIGITS;
  localparam int ACC_W      = 4 * ACC_DIGITS;
  localparam int STEP_W     = $clog2(BIN_WIDTH + 1);
  localparam int REF_W      = $clog2(REFRESH_DIV);
  localparam int SEL_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(BIN_WIDTH - 1);
  localparam logic [REF_W-1:0]  REF_MAX   = REF_W'(REFRESH_DIV - 1);
  localparam logic [SEL_W-1:0]  SEL_MAX   = SEL_W'(N_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t                state, state_nxt;
  logic [BIN_WIDTH-1:0]  shift_q;
  logic [ACC_W-1:0]      acc_q, acc_adj, acc_step;
  logic                  acc_ovf;
  logic [STEP_W-1:0]     step_q;
  logic [4*N_DIGITS-1:0] disp_q;
  logic                  disp_ovf_q;
  logic [REF_W-1:0]      ref_q;
  logic [SEL_W-1:0]      sel_q;
  logic [3:0]            digit;
  logic                  upper_zero;
  logic [7:0]            seg_code, seg_nxt;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (load) state_nxt = CONVERT;
      CONVERT: if (step_q == LAST_STEP) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------------------- double dabble
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < ACC_DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_step = (acc_adj << 1) | ACC_W'(shift_q[BIN_WIDTH-1]);
  end

  // Any non-zero digit beyond the visible ones means the value cannot be shown.
  always_comb begin
    acc_ovf = 1'b0;
    for (int i = N_DIGITS; i < ACC_DIGITS; i++) acc_ovf = acc_ovf | (|acc_q[4*i +: 4]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q    <= '0;
      acc_q      <= '0;
      step_q     <= '0;
      disp_q     <= '0;
      disp_ovf_q <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shift_q <= binary_in;
            acc_q   <= '0;
            step_q  <= '0;
          end
        end
        CONVERT: begin
          acc_q   <= acc_step;
          shift_q <= shift_q << 1;
          step_q  <= step_q + 1'b1;
        end
        UPDATE: begin
          disp_q     <= acc_q[4*N_DIGITS-1:0];
          disp_ovf_q <= acc_ovf;
          done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign overflow = disp_ovf_q;

  // ------------------------------------------------------------ scanning
  always_comb begin
    digit      = disp_q[4*sel_q +: 4];
    upper_zero = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (i >= int'(sel_q) && disp_q[4*i +: 4] != 4'd0) upper_zero = 1'b0;
    end
    case (digit)
      4'd0:    seg_code = 8'h03;
      4'd1:    seg_code = 8'h9F;
      4'd2:    seg_code = 8'h25;
      4'd3:    seg_code = 8'h0D;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h49;
      4'd6:    seg_code = 8'h41;
      4'd7:    seg_code = 8'h1F;
      4'd8:    seg_code = 8'h01;
      4'd9:    seg_code = 8'h09;
      default: seg_code = 8'hFF;
    endcase
    seg_nxt = {seg_code[7:1], ~dp_mask[sel_q]};
    // A leading-zero position keeps only its decimal point, if requested.
    if (BLANK_LZ != 0 && sel_q != '0 && upper_zero) seg_nxt = {7'h7F, ~dp_mask[sel_q]};
    if (disp_ovf_q) seg_nxt = 8'hFD;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ref_q        <= '0;
      sel_q        <= '0;
      segments_out <= 8'hFF;
      anodes_out   <= '1;
    end else begin
      if (ref_q == REF_MAX) begin
        ref_q <= '0;
        sel_q <= (sel_q == SEL_MAX) ? '0 : sel_q + 1'b1;
      end else begin
        ref_q <= ref_q + 1'b1;
      end
      if (enable) begin
        segments_out <= seg_nxt;
        anodes_out   <= ~(N_DIGITS'(1) << sel_q);
      end else begin
        segments_out <= 8'hFF;
        anodes_out   <= '1;
      end
    end
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter N_DIGITS, default 8, number of digits scanned (legal 1..8).
REQ-002 The block SHALL have parameter BIN_WIDTH, default 24, width of the unsigned binary input (legal 4..32).
REQ-003 The block SHALL have parameter REFRESH_DIV, default 65536, clock cycles per digit slot (legal >= 2).
REQ-004 The block SHALL have parameter BLANK_LZ, default 1, enabling leading-zero blanking when 1.
REQ-005 The block SHALL have port clock  in  1  single system clock, rising edge.
REQ-006 The block SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port binary_in  in  BIN_WIDTH  unsigned value to display.
REQ-008 The block SHALL have port load  in  1  capture binary_in and start conversion.
REQ-009 The block SHALL have port dp_mask  in  N_DIGITS  active-high decimal point per digit (bit 0 = units).
REQ-010 The block SHALL have port enable  in  1  low blanks all digits.
REQ-011 The block SHALL have port busy  out  1  conversion in progress.
REQ-012 The block SHALL have port done  out  1  one-cycle pulse when the display register is updated.
REQ-013 The block SHALL have port overflow  out  1  last converted value needs more than N_DIGITS digits.
REQ-014 The block SHALL have port segments_out  out  8  {a,b,c,d,e,f,g,dp}, active low.
REQ-015 The block SHALL have port anodes_out  out  N_DIGITS  active-low digit select.

Function
REQ-016 Conversion SHALL be a sequential double-dabble FSM with states IDLE, CONVERT and UPDATE.
REQ-017 In IDLE, load=1 at an edge SHALL capture binary_in, clear the BCD accumulator and enter CONVERT.
REQ-018 CONVERT SHALL perform exactly one add-3/shift step per cycle for BIN_WIDTH cycles, then enter UPDATE.
REQ-019 UPDATE SHALL copy the BCD result and overflow flag into the display register, pulse done, and return to IDLE.
REQ-020 The display register SHALL be written exactly BIN_WIDTH+1 edges after the load edge; busy SHALL be high throughout CONVERT and UPDATE.
REQ-021 load while busy=1 SHALL be ignored; it is not queued.
REQ-022 The internal BCD accumulator SHALL cover all digits BIN_WIDTH can produce; overflow SHALL be 1 when any digit above N_DIGITS-1 is non-zero.
REQ-023 When the displayed overflow is 1, every digit SHALL show "-" (8'b11111101), including dp bits.
REQ-024 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; the digit selector SHALL advance on the wrap and go from N_DIGITS-1 back to 0.
REQ-025 segments_out and anodes_out SHALL be registered and reflect the selector and display register one cycle later.
REQ-026 Digits 0..9 SHALL use codes 03,9F,25,0D,99,49,41,1F,01,09 (hex, dp=1); dp SHALL be 0 when dp_mask[sel]=1.
REQ-027 With BLANK_LZ=1, a digit above the most significant non-zero digit SHALL output 8'hFF unless its dp_mask bit is set; digit 0 SHALL never blank.
REQ-028 enable=0 SHALL force anodes_out all ones and segments_out 8'hFF; the counters SHALL keep running.
REQ-029 If an UPDATE coincides with a digit advance, the new display contents SHALL be used from the next cycle.

Reset
REQ-030 reset_n=0 SHALL asynchronously set FSM=IDLE, busy=0, done=0, overflow=0, display register=0, counters=0, segments_out=8'hFF, anodes_out all ones.
REQ-031 Reset asserted mid-conversion SHALL abort it; the display register SHALL stay 0 after release.
REQ-032 The first edge after reset release SHALL drive anodes_out = ~1 (digit 0) and segments_out=8'h03.

Verification
REQ-033 Defaults, REFRESH_DIV=4: load with binary_in=1234 -> busy high 25 cycles, done pulse at edge 25, digits 0..3 show 4,3,2,1, digits 4..7 = 8'hFF.
REQ-034 N_DIGITS=4, BIN_WIDTH=16: load 12345 -> overflow=1, all four digits show 8'hFD; then load 9999 -> overflow=0, 9,9,9,9.
REQ-035 load 0 with dp_mask=8'h04 -> digit 0 = 8'h03, digit 2 = 8'hFE, others 8'hFF.
REQ-036 Second load during CONVERT -> ignored; displayed value is that of the first load, exactly one done pulse.
REQ-037 reset_n low at CONVERT cycle 10 -> all outputs at reset values immediately; after release digit 0 shows 8'h03.
REQ-038 enable=0 for 3 refresh slots -> anodes_out all ones; on re-enable the selector is at the slot it would have reached without blanking.
